// File: rtl/usb_rst_pkg.sv
// Shared types and constants for the USB host-controller reset sequencer.
// Register map, CTRL/STATUS bit positions and FSM state encoding.
package usb_rst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_ASSERT = 2'd1;
   localparam logic [1:0] ADDR_SETTLE = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_RST   = 2;
   localparam int STAT_STATE = 4;

endpackage

// File: rtl/usb_rst_timer.sv
// Loadable down-counter that times the assert and settle phases.
// Stops at zero; load has priority over counting.
module usb_rst_timer #(
   parameter int              CNT_W   = 24,
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         value <= RST_VAL;
      else if (load)
         value <= load_val;
      else if (en && !zero)
         value <= value - 1'b1;
   end

   assign zero = (value == '0);

endmodule

// File: rtl/usb_rst_seq.sv
// Avalon-MM reset sequencer for the external USB host controller:
// holds usb_rst for ASSERT_LEN cycles, then waits SETTLE_LEN cycles.
module usb_rst_seq
   import usb_rst_pkg::*;
#(
   parameter int CNT_W      = 24,
   parameter int DEF_ASSERT = 50000,
   parameter int DEF_SETTLE = 250000,
   parameter int AUTO_START = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        hw_req,
   output logic        usb_rst,
   output logic        irq
);

   localparam logic [CNT_W-1:0] DEF_A = CNT_W'(DEF_ASSERT);
   localparam logic [CNT_W-1:0] DEF_S = CNT_W'(DEF_SETTLE);
   localparam logic [CNT_W-1:0] RST_CNT =
      (AUTO_START != 0 && DEF_ASSERT > 1) ? CNT_W'(DEF_ASSERT - 1) : '0;
   localparam state_t RST_ST = (AUTO_START != 0) ? ST_ASSERT : ST_IDLE;

   // A programmed length of 0 still gives one cycle.
   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
      return (len == '0) ? '0 : len - 1'b1;
   endfunction

   state_t           state, state_n;
   logic             done, done_n;
   logic             irq_en, irq_en_n;
   logic [CNT_W-1:0] alen, slen, slat;
   logic             ld, lat;
   logic [CNT_W-1:0] ld_val;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;
   logic             busy;

   logic wr, wr_ctrl, wr_alen, wr_slen, wr_stat;
   logic abort, start;

   assign wr      = chipselect & ~write_n;
   assign wr_ctrl = wr && (address == ADDR_CTRL);
   assign wr_alen = wr && (address == ADDR_ASSERT);
   assign wr_slen = wr && (address == ADDR_SETTLE);
   assign wr_stat = wr && (address == ADDR_STATUS);
   assign abort   = wr_ctrl & writedata[CTRL_ABORT];
   assign start   = (wr_ctrl & writedata[CTRL_START]) | hw_req;
   assign busy    = (state != ST_IDLE);

   usb_rst_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_CNT)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (ld),
      .en       (busy),
      .load_val (ld_val),
      .value    (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_n  = state;
      done_n   = done;
      irq_en_n = irq_en;
      ld       = 1'b0;
      ld_val   = '0;
      lat      = 1'b0;
      if (wr_stat && writedata[STAT_DONE])
         done_n = 1'b0;
      if (wr_ctrl)
         irq_en_n = writedata[CTRL_IRQ_EN];
      // Abort overrides everything, including a completing sequence.
      if (abort) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state_n = ST_ASSERT;
                  ld      = 1'b1;
                  ld_val  = len_m1(alen);
                  lat     = 1'b1;
                  done_n  = 1'b0;
               end
            end
            ST_ASSERT: begin
               if (cnt_zero) begin
                  state_n = ST_SETTLE;
                  ld      = 1'b1;
                  ld_val  = len_m1(slat);
               end
            end
            ST_SETTLE: begin
               if (cnt_zero) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= RST_ST;
         usb_rst <= (AUTO_START != 0);
         done    <= 1'b0;
         irq_en  <= 1'b0;
         irq     <= 1'b0;
         alen    <= DEF_A;
         slen    <= DEF_S;
         slat    <= DEF_S;
      end else begin
         state   <= state_n;
         usb_rst <= (state_n == ST_ASSERT);
         done    <= done_n;
         irq_en  <= irq_en_n;
         irq     <= done_n & irq_en_n;
         if (wr_alen)
            alen <= writedata[CNT_W-1:0];
         if (wr_slen)
            slen <= writedata[CNT_W-1:0];
         if (lat)
            slat <= slen;
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_CTRL:   readdata[CTRL_IRQ_EN] = irq_en;
         ADDR_ASSERT: readdata[CNT_W-1:0]   = alen;
         ADDR_SETTLE: readdata[CNT_W-1:0]   = slen;
         ADDR_STATUS: begin
            readdata[STAT_BUSY]       = busy;
            readdata[STAT_DONE]       = done;
            readdata[STAT_RST]        = usb_rst;
            readdata[STAT_STATE +: 2] = state;
         end
         default: readdata = '0;
      endcase
   end

   logic unused_bits;
   assign unused_bits = ^{writedata, cnt_val};

endmodule

// File: tb/tb_usb_rst_seq.sv
// Bench for usb_rst_seq: table vectors, directed corner sequences and
// random bus traffic checked against a cycle-time reference model.
module tb_usb_rst_seq;

   localparam int CW = 24;
   localparam int DA = 20;
   localparam int DS = 30;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic        hw_req = 1'b0;
   logic [31:0] rd_m, rd_a;
   logic        rst_m, rst_a, irq_m, irq_a;

   always #5 clk = ~clk;

   usb_rst_seq #(
      .CNT_W(CW), .DEF_ASSERT(DA), .DEF_SETTLE(DS), .AUTO_START(0)
   ) u_man (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(rd_m), .hw_req(hw_req), .usb_rst(rst_m), .irq(irq_m)
   );

   usb_rst_seq #(
      .CNT_W(CW), .DEF_ASSERT(DA), .DEF_SETTLE(DS), .AUTO_START(1)
   ) u_auto (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(rd_a), .hw_req(hw_req), .usb_rst(rst_a), .irq(irq_a)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a sequence is a window of absolute cycle numbers.
   int m_cyc, m_rend, m_end, m_alen, m_slen;
   bit m_act, m_done, m_ien;

   function automatic int mx1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic m_reset();
      m_cyc  = 0;
      m_act  = 0;
      m_done = 0;
      m_ien  = 0;
      m_alen = DA;
      m_slen = DS;
   endtask

   function automatic bit m_rst();
      return m_act && (m_cyc <= m_rend);
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] r;
      int st;
      st = !m_act ? 0 : (m_cyc <= m_rend ? 1 : 2);
      case (a)
         2'd0:    r = {29'd0, m_ien, 2'd0};
         2'd1:    r = m_alen;
         2'd2:    r = m_slen;
         default: r = {26'd0, st[1:0], 1'b0, m_rst(), m_done, m_act};
      endcase
      return r;
   endfunction

   task automatic m_step();
      bit wr, ab, st;
      wr = chipselect && !write_n;
      ab = wr && address == 2'd0 && writedata[1];
      st = ((wr && address == 2'd0 && writedata[0]) || hw_req) && !ab;
      if (wr && address == 2'd3 && writedata[1]) m_done = 0;
      if (ab) begin
         m_act = 0;
      end else if (m_act && m_cyc == m_end) begin
         m_act  = 0;
         m_done = 1;
      end else if (!m_act && st) begin
         m_act  = 1;
         m_rend = m_cyc + mx1(m_alen);
         m_end  = m_rend + mx1(m_slen);
         m_done = 0;
      end
      if (wr && address == 2'd0) m_ien = writedata[2];
      if (wr && address == 2'd1) m_alen = int'(writedata[CW-1:0]);
      if (wr && address == 2'd2) m_slen = int'(writedata[CW-1:0]);
      m_cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      chk("readdata", rd_m, m_read(address));
      m_step();
      @(posedge clk);
      #1;
      chk("usb_rst", rst_m, m_rst());
      chk("irq", irq_m, m_done & m_ien);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      #1;
   endtask

   typedef struct {
      logic        cs;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[9];
   int   n;

   initial begin
      vt[0] = '{1'b1, 2'd1, 32'h0000_0007, 32'h0000_0007};
      vt[1] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
      vt[2] = '{1'b0, 2'd1, 32'h0000_0003, 32'h00FF_FFFF};
      vt[3] = '{1'b1, 2'd1, 32'h0000_0003, 32'h0000_0003};
      vt[4] = '{1'b1, 2'd2, 32'hAB00_0000, 32'h0000_0000};
      vt[5] = '{1'b1, 2'd2, 32'h0000_0002, 32'h0000_0002};
      vt[6] = '{1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0000_0004};
      vt[7] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_0000};
      vt[8] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};

      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rd(2'd3);
      chk("man_reset_status", rd_m, 32'h0);
      chk("auto_reset_status", rd_a, 32'h15);
      chk("man_reset_rst", rst_m, 1'b0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;

      // Auto-start after reset release.
      n = 0;
      while (rst_a && n < DA + 5) begin n++; tick(); end
      chk("auto_assert_cycles", n, DA);
      n = 0;
      while (rd_a[0] && n < DS + 5) begin n++; tick(); end
      chk("auto_settle_cycles", n, DS);
      chk("auto_done", rd_a[1], 1'b1);
      chk("auto_irq", irq_a, 1'b0);

      // Register table.
      for (int i = 0; i < 9; i++) begin
         address    = vt[i].addr;
         chipselect = vt[i].cs;
         write_n    = 1'b0;
         writedata  = vt[i].wdata;
         tick();
         chipselect = 1'b0;
         write_n    = 1'b1;
         writedata  = '0;
         rd(vt[i].addr);
         chk($sformatf("table%0d", i), rd_m, vt[i].exp);
      end

      // 3/2 sequence with interrupt, then W1C.
      wr(2'd0, 32'h4);
      wr(2'd0, 32'h5);
      for (int k = 1; k <= 6; k++) begin
         rd(2'd3);
         chk($sformatf("seq32_rst_k%0d", k), rst_m, k <= 3);
         chk($sformatf("seq32_done_k%0d", k), rd_m[1], k >= 6);
         chk($sformatf("seq32_irq_k%0d", k), irq_m, k >= 6);
         if (k < 6) tick();
      end
      wr(2'd3, 32'h2);
      chk("w1c_irq", irq_m, 1'b0);
      rd(2'd3);
      chk("w1c_status", rd_m, 32'h0);

      // Zero lengths: one cycle each.
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h0);
      wr(2'd0, 32'h1);
      rd(2'd3);
      chk("zero_k1", rd_m, 32'h15);
      tick();
      rd(2'd3);
      chk("zero_k2", rd_m, 32'h21);
      tick();
      rd(2'd3);
      chk("zero_k3", rd_m, 32'h02);

      // Start while busy ignored; length write mid-sequence deferred.
      wr(2'd1, 32'h3);
      wr(2'd2, 32'h2);
      wr(2'd0, 32'h1);
      tick();
      hw_req = 1'b1;
      wr(2'd0, 32'h1);
      hw_req = 1'b0;
      tick();
      wr(2'd1, 32'd10);
      rd(2'd3);
      chk("nore_settle", rd_m, 32'h21);
      tick();
      rd(2'd3);
      chk("nore_done", rd_m, 32'h02);
      wr(2'd0, 32'h1);
      n = 0;
      while (rst_m && n < 20) begin n++; tick(); end
      chk("len10_assert", n, 10);
      n = 0;
      rd(2'd3);
      while (rd_m[0] && n < 20) begin n++; tick(); end
      chk("len10_settle", n, 2);

      // Abort during assert.
      wr(2'd1, 32'd100);
      wr(2'd0, 32'h1);
      repeat (39) tick();
      wr(2'd0, 32'h2);
      rd(2'd3);
      chk("abort_status", rd_m, 32'h0);
      chk("abort_rst", rst_m, 1'b0);
      wr(2'd0, 32'h3);
      repeat (3) tick();
      rd(2'd3);
      chk("start_abort_idle", rd_m, 32'h0);

      // Async reset mid-settle.
      wr(2'd1, 32'd4);
      wr(2'd2, 32'd50);
      wr(2'd0, 32'h1);
      repeat (6) tick();
      rd(2'd3);
      chk("pre_reset_settle", rd_m, 32'h21);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_usb_rst", rst_m, 1'b0);
      chk("rst_status", rd_m, 32'h0);
      chk("rst_irq", irq_m, 1'b0);
      chk("rst_auto_status", rd_a, 32'h15);
      rd(2'd1);
      chk("rst_alen", rd_m, DA);
      rd(2'd2);
      chk("rst_slen", rd_m, DS);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_reset();

      // Random traffic against the model.
      wr(2'd1, 32'd2);
      wr(2'd2, 32'd3);
      repeat (3000) begin
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = 1'($urandom_range(0, 1));
         writedata  = (address == 2'd1 || address == 2'd2)
                      ? 32'($urandom_range(0, 6)) : $urandom;
         hw_req     = ($urandom_range(0, 15) == 0);
         tick();
         chipselect = 1'b0;
         write_n    = 1'b1;
         hw_req     = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
